// File: rtl/wb_arbiter.sv
// Write-back arbiter: three producers feed private 2-entry FIFOs that a
// round-robin scheduler drains, one entry per cycle, onto a registered write port.

module wb_arb_fifo #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         ready,
    input  logic [W-1:0] push_entry,
    input  logic         pop,
    output logic         nonempty,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [2];
    logic         wp, rp;
    logic [1:0]   count;
    logic         push, do_pop;

    // ready comes from the registered count only, so a pop in the same cycle
    // never reopens a full FIFO early.
    assign ready    = (count < 2'd2);
    assign nonempty = (count != 2'd0);
    assign push     = push_valid & ready;
    assign do_pop   = pop & nonempty;
    assign head     = mem[rp];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push)   wp <= ~wp;
            if (do_pop) rp <= ~rp;
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= push_entry;
    end
endmodule

module wb_arbiter #(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [W_ADDR-1:0] alu_addr_i,
    input  logic [W_DATA-1:0] alu_data_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [W_ADDR-1:0] ld_addr_i,
    input  logic [W_DATA-1:0] ld_data_i,
    input  logic              br_valid_i,
    output logic              br_ready_o,
    input  logic [W_ADDR-1:0] br_addr_i,
    input  logic [W_DATA-1:0] br_data_i,
    output logic              wb_o,
    output logic [W_ADDR-1:0] wb_r_o,
    output logic [W_DATA-1:0] wb_data_o,
    output logic              stall_o,
    output logic              busy_o
);
    localparam int N_SRC = 3;
    localparam int W_ENT = W_ADDR + W_DATA;

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic [W_DATA-1:0] data;
    } wb_ent_t;

    logic [N_SRC-1:0]            src_valid, src_ready, nonempty, pop;
    logic [N_SRC-1:0][W_ENT-1:0] src_entry, head;
    logic [1:0]                  rr, rr_base, cand, gnt_idx;
    logic                        gnt_vld;
    wb_ent_t                     gnt_ent;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [2:0] t;
        t = (v >= 3'd3) ? v - 3'd3 : v;
        return t[1:0];
    endfunction

    assign src_valid = {br_valid_i, ld_valid_i, alu_valid_i};
    assign src_entry = {{br_addr_i, br_data_i}, {ld_addr_i, ld_data_i}, {alu_addr_i, alu_data_i}};

    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            wb_arb_fifo #(.W(W_ENT)) u_fifo (
                .clk        (clk),
                .rst        (rst),
                .push_valid (src_valid[i]),
                .ready      (src_ready[i]),
                .push_entry (src_entry[i]),
                .pop        (pop[i]),
                .nonempty   (nonempty[i]),
                .head       (head[i])
            );
        end
    endgenerate

    assign alu_ready_o = src_ready[0];
    assign ld_ready_o  = src_ready[1];
    assign br_ready_o  = src_ready[2];
    assign stall_o     = ~&src_ready;
    assign busy_o      = (|nonempty) | wb_o;

    // Scan from the farthest slot back to rr so the nearest candidate wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        rr_base = (rr == 2'd3) ? 2'd0 : rr;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = wrap3({1'b0, rr_base} + 3'(k));
            if (nonempty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (gnt_vld) pop[gnt_idx] = 1'b1;
    end

    assign gnt_ent = wb_ent_t'(head[gnt_idx]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr        <= 2'd0;
            wb_o      <= 1'b0;
            wb_r_o    <= '0;
            wb_data_o <= '0;
        end else begin
            wb_o <= gnt_vld;
            if (gnt_vld) begin
                rr        <= wrap3({1'b0, gnt_idx} + 3'd1);
                wb_r_o    <= gnt_ent.addr;
                wb_data_o <= gnt_ent.data;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, round-robin order, back-pressure,
// pointer wrap and asynchronous reset mid-drain.

module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid_i = 1'b0, ld_valid_i = 1'b0, br_valid_i = 1'b0;
    logic        alu_ready_o, ld_ready_o, br_ready_o;
    logic [3:0]  alu_addr_i = '0, ld_addr_i = '0, br_addr_i = '0;
    logic [31:0] alu_data_i = '0, ld_data_i = '0, br_data_i = '0;
    logic        wb_o, stall_o, busy_o;
    logic [3:0]  wb_r_o;
    logic [31:0] wb_data_o;

    int n_cmp = 0;
    int n_err = 0;

    wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
        .ld_valid_i(ld_valid_i),   .ld_ready_o(ld_ready_o),   .ld_addr_i(ld_addr_i),   .ld_data_i(ld_data_i),
        .br_valid_i(br_valid_i),   .br_ready_o(br_ready_o),   .br_addr_i(br_addr_i),   .br_data_i(br_data_i),
        .wb_o(wb_o), .wb_r_o(wb_r_o), .wb_data_o(wb_data_o), .stall_o(stall_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic chk_wb(input string tag, input logic [3:0] a, input logic [31:0] d);
        chk({tag, ".wb"},   32'(wb_o), 32'd1);
        chk({tag, ".addr"}, 32'(wb_r_o), 32'(a));
        chk({tag, ".data"}, wb_data_o, d);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst.wb", 32'(wb_o), 0);
        chk("rst.addr", 32'(wb_r_o), 0);
        chk("rst.data", wb_data_o, 0);
        chk("rst.ready", {29'd0, br_ready_o, ld_ready_o, alu_ready_o}, 32'h7);
        chk("rst.stall", 32'(stall_o), 0);
        chk("rst.busy", 32'(busy_o), 0);
        rst = 1'b1;

        // single ALU push: write appears after the second edge only
        alu_valid_i = 1; alu_addr_i = 4'd3; alu_data_i = 32'h0000_1234;
        tick();
        alu_valid_i = 0;
        chk("t1.e1.wb", 32'(wb_o), 0);
        chk("t1.e1.busy", 32'(busy_o), 1);
        tick();
        chk_wb("t1.e2", 4'd3, 32'h0000_1234);
        chk("t1.e2.busy", 32'(busy_o), 1);
        tick();
        chk("t1.e3.wb", 32'(wb_o), 0);
        chk("t1.e3.busy", 32'(busy_o), 0);

        // three simultaneous pushes drain alu, ld, br
        do_reset();
        alu_valid_i = 1; alu_addr_i = 4'd1; alu_data_i = 32'hA;
        ld_valid_i  = 1; ld_addr_i  = 4'd2; ld_data_i  = 32'hB;
        br_valid_i  = 1; br_addr_i  = 4'd3; br_data_i  = 32'hC;
        tick();
        alu_valid_i = 0; ld_valid_i = 0; br_valid_i = 0;
        chk("t2.e1.wb", 32'(wb_o), 0);
        tick(); chk_wb("t2.alu", 4'd1, 32'hA);
        tick(); chk_wb("t2.ld",  4'd2, 32'hB);
        tick(); chk_wb("t2.br",  4'd3, 32'hC);
        tick();
        chk("t2.idle.wb", 32'(wb_o), 0);
        chk("t2.idle.busy", 32'(busy_o), 0);
        // rr back at 0: alu beats ld
        alu_valid_i = 1; alu_addr_i = 4'd4; alu_data_i = 32'h40;
        ld_valid_i  = 1; ld_addr_i  = 4'd5; ld_data_i  = 32'h50;
        tick();
        alu_valid_i = 0; ld_valid_i = 0;
        tick(); chk_wb("t2.rr.alu", 4'd4, 32'h40);
        tick(); chk_wb("t2.rr.ld",  4'd5, 32'h50);

        // ld streaming 4 entries against 2 queued alu entries
        do_reset();
        alu_valid_i = 1; alu_addr_i = 4'd1; alu_data_i = 32'hA0;
        ld_valid_i  = 1; ld_addr_i  = 4'd2; ld_data_i  = 32'h10;
        tick();                                   // E1
        alu_data_i = 32'hA1; ld_data_i = 32'h11;
        tick();                                   // E2
        alu_valid_i = 0; ld_data_i = 32'h12;
        chk_wb("t3.e2", 4'd1, 32'hA0);
        chk("t3.e2.ldrdy", 32'(ld_ready_o), 0);
        chk("t3.e2.stall", 32'(stall_o), 1);
        tick();                                   // E3
        chk_wb("t3.e3", 4'd2, 32'h10);
        chk("t3.e3.ldrdy", 32'(ld_ready_o), 1);
        chk("t3.e3.stall", 32'(stall_o), 0);
        tick();                                   // E4
        ld_data_i = 32'h13;
        chk_wb("t3.e4", 4'd1, 32'hA1);
        chk("t3.e4.ldrdy", 32'(ld_ready_o), 0);
        chk("t3.e4.stall", 32'(stall_o), 1);
        tick();                                   // E5
        chk_wb("t3.e5", 4'd2, 32'h11);
        chk("t3.e5.ldrdy", 32'(ld_ready_o), 1);
        tick();                                   // E6
        ld_valid_i = 0;
        chk_wb("t3.e6", 4'd2, 32'h12);
        tick(); chk_wb("t3.e7", 4'd2, 32'h13);
        tick(); chk("t3.e8.wb", 32'(wb_o), 0);

        // fill alu FIFO while ld/br hold the arbiter
        do_reset();
        alu_valid_i = 1; alu_addr_i = 4'd5; alu_data_i = 32'hD0;
        ld_valid_i  = 1; ld_addr_i  = 4'd6; ld_data_i  = 32'h66;
        br_valid_i  = 1; br_addr_i  = 4'd7; br_data_i  = 32'h77;
        tick();                                   // E1
        ld_valid_i = 0; br_valid_i = 0; alu_data_i = 32'hD1;
        tick();                                   // E2
        alu_data_i = 32'hD2;
        chk_wb("t4.e2", 4'd5, 32'hD0);
        tick();                                   // E3
        alu_data_i = 32'hD3;
        chk_wb("t4.e3", 4'd6, 32'h66);
        chk("t4.e3.alurdy", 32'(alu_ready_o), 0);
        chk("t4.e3.stall", 32'(stall_o), 1);
        tick();                                   // E4
        chk_wb("t4.e4", 4'd7, 32'h77);
        chk("t4.e4.alurdy", 32'(alu_ready_o), 0);
        tick();                                   // E5
        alu_valid_i = 0;
        chk_wb("t4.e5", 4'd5, 32'hD1);
        chk("t4.e5.alurdy", 32'(alu_ready_o), 1);
        chk("t4.e5.stall", 32'(stall_o), 0);
        tick(); chk_wb("t4.e6", 4'd5, 32'hD2);
        tick();
        chk("t4.e7.wb", 32'(wb_o), 0);
        chk("t4.e7.busy", 32'(busy_o), 0);

        // six br entries with alternating patterns across pointer wraps
        do_reset();
        for (int i = 0; i < 6; i++) begin
            br_valid_i = 1; br_addr_i = 4'(i + 8);
            br_data_i  = (i % 2 == 0) ? 32'hAAAA_0000 : 32'h5555_FFFF;
            tick();
            if (i > 0) chk_wb($sformatf("t5.w%0d", i - 1), 4'(i + 7),
                              ((i - 1) % 2 == 0) ? 32'hAAAA_0000 : 32'h5555_FFFF);
        end
        br_valid_i = 0;
        tick(); chk_wb("t5.w5", 4'd13, 32'h5555_FFFF);
        tick(); chk("t5.idle.wb", 32'(wb_o), 0);

        // asynchronous reset while writing with two entries still queued
        do_reset();
        alu_valid_i = 1; alu_addr_i = 4'd1; alu_data_i = 32'h111;
        ld_valid_i  = 1; ld_addr_i  = 4'd2; ld_data_i  = 32'h222;
        br_valid_i  = 1; br_addr_i  = 4'd3; br_data_i  = 32'h333;
        tick();
        alu_valid_i = 0; ld_valid_i = 0; br_valid_i = 0;
        tick();
        chk_wb("t6.pre", 4'd1, 32'h111);
        chk("t6.pre.busy", 32'(busy_o), 1);
        #1 rst = 1'b0;
        #1;
        chk("t6.rst.wb", 32'(wb_o), 0);
        chk("t6.rst.addr", 32'(wb_r_o), 0);
        chk("t6.rst.data", wb_data_o, 0);
        chk("t6.rst.busy", 32'(busy_o), 0);
        chk("t6.rst.stall", 32'(stall_o), 0);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6.post%0d.wb", i), 32'(wb_o), 0);
            chk($sformatf("t6.post%0d.busy", i), 32'(busy_o), 0);
            chk($sformatf("t6.post%0d.ready", i), {29'd0, br_ready_o, ld_ready_o, alu_ready_o}, 32'h7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sharing the register file's single write port (wb_i / wb_r_i / wb_data_i of the decode stage) among three result producers: the ALU path (integer/logic/shift), the load unit and the branch/link unit. Each producer pushes results through a valid/ready handshake into a private 2-entry FIFO. A round-robin scheduler drains one entry per cycle onto a registered write-back port. Back-pressure is returned as per-source ready and a global stall.

## Interface
- W_DATA, 32, write-back data width
- W_ADDR, 4, register address width
- DEPTH, 2, entries per source FIFO (fixed at 2; count is 2 bits)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- alu_valid_i  in  1  ALU result present
- alu_ready_o  out  1  ALU FIFO can accept
- alu_addr_i  in  W_ADDR  ALU destination register
- alu_data_i  in  W_DATA  ALU result
- ld_valid_i / ld_ready_o / ld_addr_i / ld_data_i  same as ALU, load unit
- br_valid_i / br_ready_o / br_addr_i / br_data_i  same as ALU, branch/link unit
- wb_o  out  1  register-file write enable (drives wb_i)
- wb_r_o  out  W_ADDR  write target (drives wb_r_i)
- wb_data_o  out  W_DATA  write data (drives wb_data_i)
- stall_o  out  1  any source FIFO full
- busy_o  out  1  any entry queued or write in flight

## Operation
- Source index: alu=0, ld=1, br=2.
- Push: an entry is accepted at a rising edge when valid_i & ready_o. ready_o = (count < 2), from registered count only. No same-cycle pop pass-through: a full FIFO deasserts ready even if it is popped that cycle.
- FIFO: per source, 2 entries of {addr, data}, write pointer, read pointer (1 bit each, wrap 1→0), count 0..2. Simultaneous push and pop leaves count unchanged.
- Arbitration is combinational over FIFO heads each cycle. Candidates are sources with count ≠ 0.
  - Search order: rr, rr+1, rr+2, all mod 3.
  - The first candidate found is granted and popped at the next edge.
- rr pointer: 2-bit register, legal values 0..2, reset 0. After a grant to g, rr <= (g+1) mod 3. rr holds when there is no grant.
- Output register, loaded at the edge following the grant:
  - grant: wb_o <= 1, wb_r_o <= head addr, wb_data_o <= head data
  - no grant: wb_o <= 0; wb_r_o and wb_data_o hold their previous values
- Ordering: no cross-source ordering is enforced. Decode-stage register reservation guarantees at most one outstanding write per register. Within one source, FIFO order is preserved.
- stall_o = ~alu_ready_o | ~ld_ready_o | ~br_ready_o (combinational from counts).
- busy_o = (any count ≠ 0) | wb_o.
- Reset (asynchronous, any time including mid-drain):
  - all counts and pointers 0; rr = 0
  - wb_o = 0, wb_r_o = 0, wb_data_o = 0
  - ready outputs = 1, stall_o = 0, busy_o = 0
  - queued entries are discarded, never written

## Timing
- Latency, uncontended: push accepted at edge k → grant during cycle k..k+1 → wb_o = 1 after edge k+1. Two edges total.
- Throughput: one write-back per cycle aggregate. Each source is served at least once every 3 cycles while non-empty.
- ready_o falls the cycle after the second unpopped push. It rises the cycle after a pop reduces count to 1.
- wb_o is a single-cycle pulse per entry. Back-to-back grants give wb_o continuously high with new addr/data each cycle.
- Simultaneous push to an empty FIFO and arbitration: the new entry is not visible to the arbiter until the next cycle (count is registered).
- All outputs except ready/stall_o/busy_o are registered; those three are combinational from registered state.

## Test plan
- Single ALU push (addr 3, data 0x0000_1234) at edge 1 → wb_o = 1, wb_r_o = 3, wb_data_o = 0x1234 after edge 2 only. busy_o falls after edge 3.
- All three sources push once at the same edge with rr = 0 → writes on three consecutive cycles in order alu, ld, br. rr = 0 afterwards.
- ld held valid, pushing 4 entries, while alu also has 2 queued → writes alternate alu, ld, alu, ld, then ld, ld. ld_ready_o is low while count = 2. stall_o tracks it.
- Fill ALU FIFO (2 pushes, no drain possible on cycle 1) → alu_ready_o = 0 and stall_o = 1 the following cycle. A third valid is not accepted. Data order is preserved on drain.
- Push alternating data 0xAAAA_0000 / 0x5555_FFFF through br for 6 entries → pointer wrap is correct and all six are written in order.
- rst low while 2 entries are queued and wb_o = 1 → all outputs reach reset values immediately. After rst high, no stale write appears; ready = 1.
